// File: rtl/risc_toy_pkg.sv
// Types and widths shared by the RISC_toy datapath and the unified-memory port arbiter.
package risc_toy_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } arb_state_t;

  typedef enum logic {
    G_FETCH,
    G_DATA
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage: one transaction at a
// time, one-cycle acks, per-transaction wait timeout and combinational stall lines.
module mem_port_arbiter
  import risc_toy_pkg::*;
#(
  parameter int unsigned AW       = ADDR_W,
  parameter int unsigned DW       = DATA_W,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dreq,
  input  logic          drw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err_timeout
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  arb_state_t    state_q;
  grant_t        last_grant_q;
  logic [7:0]    wait_cnt_q;
  logic          if_ack_q, d_ack_q, m_req_q, m_we_q, err_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q, if_rdata_q, d_rdata_q;

  logic       if_pend, d_pend, grant_f, grant_d, busy, timeout;
  logic [7:0] wait_nxt;

  // A requester is still high during its own ack cycle, so it must not be re-granted then.
  assign if_pend  = if_req & ~if_ack_q;
  assign d_pend   = dreq & ~d_ack_q;
  assign busy     = (state_q == FETCH) || (state_q == DATA);
  assign wait_nxt = wait_cnt_q + 8'd1;
  assign timeout  = busy & ~m_ready & (wait_nxt == MaxWait);

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (if_pend && d_pend) begin
        grant_d = (last_grant_q == G_FETCH);
        grant_f = (last_grant_q == G_DATA);
      end else begin
        grant_f = if_pend;
        grant_d = d_pend;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      last_grant_q <= G_FETCH;
      wait_cnt_q   <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      err_q        <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (grant_d) begin
            state_q      <= DATA;
            last_grant_q <= G_DATA;
            m_req_q      <= 1'b1;
            m_we_q       <= drw;
            m_addr_q     <= d_addr;
            m_wdata_q    <= d_wdata;
          end else if (grant_f) begin
            state_q      <= FETCH;
            last_grant_q <= G_FETCH;
            m_req_q      <= 1'b1;
            m_we_q       <= 1'b0;
            m_addr_q     <= if_addr;
          end
        end
        FETCH, DATA: begin
          if (m_ready || timeout) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            wait_cnt_q <= '0;
            if (!m_ready) err_q <= 1'b1;
            if (state_q == FETCH) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= m_ready ? m_rdata : '0;
            end else begin
              d_ack_q <= 1'b1;
              // Writes leave the load-data register untouched unless aborted.
              if (!m_ready)     d_rdata_q <= '0;
              else if (!m_we_q) d_rdata_q <= m_rdata;
            end
          end else begin
            wait_cnt_q <= wait_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_rdata     = d_rdata_q;
  assign d_ack       = d_ack_q;
  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign err_timeout = err_q;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall_if    = RSTN & if_req & ~if_ack_q;
  assign stall_mem   = RSTN & dreq & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int unsigned MaxWait = 4;

  logic        CLK, RSTN;
  logic        if_req, if_ack, dreq, drw, d_ack, m_req, m_we, m_ready;
  logic        stall_if, stall_mem, err_timeout;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MaxWait)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dreq(dreq), .drw(drw), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .stall_if(stall_if), .stall_mem(stall_mem),
    .err_timeout(err_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the transaction in flight plus the history of grants.
  typedef struct {
    bit          active;
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waited;
  } txn_t;

  txn_t        cur;
  bit          grant_log[$];
  bit          e_if_ack, e_d_ack, e_err;
  logic [31:0] e_if_rdata, e_d_rdata;

  function automatic void model_reset();
    cur.active = 0;
    cur.is_data = 0;
    cur.we = 0;
    cur.addr = '0;
    cur.wdata = '0;
    cur.waited = 0;
    grant_log.delete();
    e_if_ack = 0;
    e_d_ack = 0;
    e_err = 0;
    e_if_rdata = '0;
    e_d_rdata = '0;
  endfunction

  function automatic void model_step();
    bit n_if_ack = 0;
    bit n_d_ack = 0;
    bit close = 0;
    bit want_f, want_d, last_data, take_d;
    if (cur.active) begin
      if (m_ready) begin
        if (!cur.is_data) e_if_rdata = m_rdata;
        else if (!cur.we) e_d_rdata = m_rdata;
        close = 1;
      end else if (cur.waited + 1 >= int'(MaxWait)) begin
        if (cur.is_data) e_d_rdata = '0;
        else e_if_rdata = '0;
        e_err = 1;
        close = 1;
      end else begin
        cur.waited++;
      end
      if (close) begin
        cur.active = 0;
        if (cur.is_data) n_d_ack = 1;
        else n_if_ack = 1;
      end
    end else begin
      want_f = if_req && !e_if_ack;
      want_d = dreq && !e_d_ack;
      if (want_f || want_d) begin
        last_data = (grant_log.size() > 0) ? grant_log[$] : 1'b0;
        take_d = want_d && (!want_f || !last_data);
        grant_log.push_back(take_d);
        cur.active = 1;
        cur.is_data = take_d;
        cur.we = take_d && drw;
        cur.addr = take_d ? d_addr : if_addr;
        cur.wdata = d_wdata;
        cur.waited = 0;
      end
    end
    e_if_ack = n_if_ack;
    e_d_ack = n_d_ack;
  endfunction

  // Compare process: outputs are settled mid-cycle, inputs for the next edge are stable.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        model_reset();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_stall_if", 32'(stall_if), 32'd0);
        chk("rst_stall_mem", 32'(stall_mem), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
      end else begin
        chk("m_req", 32'(m_req), 32'(cur.active));
        chk("m_we", 32'(m_we), 32'(cur.active && cur.we));
        if (cur.active) chk("m_addr", m_addr, cur.addr);
        if (cur.active && cur.we) chk("m_wdata", m_wdata, cur.wdata);
        chk("if_ack", 32'(if_ack), 32'(e_if_ack));
        chk("d_ack", 32'(d_ack), 32'(e_d_ack));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("err_timeout", 32'(err_timeout), 32'(e_err));
        chk("stall_if", 32'(stall_if), 32'(if_req && !e_if_ack));
        chk("stall_mem", 32'(stall_mem), 32'(dreq && !e_d_ack));
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  bit          f_done, d_done;
  int unsigned p_ready;

  task automatic rand_drive();
    if (if_req && if_ack) f_done = 1;
    else if (f_done) begin
      f_done = 0;
      if ($urandom_range(3) == 0) if_addr = $urandom;
      else if_req = 0;
    end else if (!if_req) begin
      if ($urandom_range(2) == 0) begin
        if_req = 1;
        if_addr = $urandom;
      end
    end else begin
      if ($urandom_range(15) == 0) if_addr = $urandom;
      if ($urandom_range(63) == 0) if_req = 0;
    end
    if (dreq && d_ack) d_done = 1;
    else if (d_done) begin
      d_done = 0;
      if ($urandom_range(3) == 0) begin
        d_addr = $urandom;
        d_wdata = $urandom;
        drw = 1'($urandom_range(1));
      end else dreq = 0;
    end else if (!dreq) begin
      if ($urandom_range(2) == 0) begin
        dreq = 1;
        drw = 1'($urandom_range(1));
        d_addr = $urandom;
        d_wdata = $urandom;
      end
    end else begin
      if ($urandom_range(15) == 0) d_addr = $urandom;
      if ($urandom_range(63) == 0) dreq = 0;
    end
    m_ready = ($urandom_range(99) < p_ready);
    m_rdata = $urandom;
  endtask

  logic [31:0] grants[8];
  int          ng;
  logic        prev_req;

  initial begin
    RSTN = 0; if_req = 0; dreq = 0; drw = 0; m_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    f_done = 0; d_done = 0; p_ready = 70;
    foreach (grants[i]) grants[i] = '0;

    tick();
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_m_addr", m_addr, 32'h0);
    tick();
    RSTN = 1;

    // Lone fetch, with m_ready already high in IDLE.
    m_ready = 1; m_rdata = 32'h12345678;
    tick(); tick();
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("lone_m_req", 32'(m_req), 32'd1);
    chk("lone_m_addr", m_addr, 32'h100);
    chk("lone_stall_if_c1", 32'(stall_if), 32'd1);
    tick();
    chk("lone_if_ack", 32'(if_ack), 32'd1);
    chk("lone_if_rdata", if_rdata, 32'h12345678);
    chk("lone_stall_if_ack", 32'(stall_if), 32'd0);
    tick();
    chk("mask_no_regrant", 32'(m_req), 32'd0);
    if_req = 0;

    // Simultaneous requests, data write wins, three wait states.
    tick(); tick();
    m_ready = 0;
    if_req = 1; if_addr = 32'h300;
    dreq = 1; drw = 1; d_addr = 32'h200; d_wdata = 32'hA5A5A5A5;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("conf_m_req", 32'(m_req), 32'd1);
      chk("conf_m_we", 32'(m_we), 32'd1);
      chk("conf_m_addr", m_addr, 32'h200);
      chk("conf_m_wdata", m_wdata, 32'hA5A5A5A5);
      if (i == 1) d_addr = 32'hDEAD0000;
      if (i == 4) m_ready = 1;
    end
    tick();
    chk("conf_d_ack", 32'(d_ack), 32'd1);
    chk("conf_m_req_drop", 32'(m_req), 32'd0);
    tick();
    chk("conf_fetch_grant", 32'(m_req), 32'd1);
    chk("conf_fetch_addr", m_addr, 32'h300);
    chk("conf_fetch_we", 32'(m_we), 32'd0);
    dreq = 0;
    tick();
    chk("conf_if_ack", 32'(if_ack), 32'd1);
    chk("conf_if_rdata", if_rdata, 32'h12345678);
    tick();
    if_req = 0;

    // Sustained contention: grants must alternate D, F, D, F.
    tick(); tick();
    if_req = 1; if_addr = 32'h400;
    dreq = 1; drw = 0; d_addr = 32'h800;
    m_ready = 1; m_rdata = 32'hCAFEF00D;
    ng = 0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      prev_req = m_req;
      tick();
      if (m_req && !prev_req) begin
        grants[ng] = m_addr;
        ng++;
      end
    end
    if_req = 0; dreq = 0;
    chk("contend_count", 32'(ng), 32'd8);
    for (int i = 0; i < 8; i++) chk("contend_order", grants[i], (i % 2 == 0) ? 32'h800 : 32'h400);
    tick(); tick(); tick();
    chk("contend_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("err_before_timeout", 32'(err_timeout), 32'd0);

    // Timeout on a data read that memory never answers.
    m_ready = 0; dreq = 1; drw = 0; d_addr = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_m_req_high", 32'(m_req), 32'd1);
    end
    tick();
    chk("to_m_req_low", 32'(m_req), 32'd0);
    chk("to_d_ack", 32'(d_ack), 32'd1);
    chk("to_d_rdata", d_rdata, 32'h0);
    chk("to_err", 32'(err_timeout), 32'd1);
    tick();
    dreq = 0;
    tick(); tick();
    chk("to_err_sticky", 32'(err_timeout), 32'd1);

    // Reset mid-transaction, then the first conflict must go to data.
    dreq = 1; drw = 1; d_addr = 32'h600; d_wdata = 32'h11112222;
    tick();
    chk("rm_m_req", 32'(m_req), 32'd1);
    #2;
    RSTN = 0;
    #1;
    chk("rm_m_req_async", 32'(m_req), 32'd0);
    chk("rm_stall_mem", 32'(stall_mem), 32'd0);
    chk("rm_d_ack", 32'(d_ack), 32'd0);
    chk("rm_err", 32'(err_timeout), 32'd0);
    @(posedge CLK);
    #1;
    RSTN = 1;
    if_req = 1; if_addr = 32'h500; drw = 0; m_ready = 1;
    tick();
    chk("rm_first_grant", m_addr, 32'h600);
    chk("rm_first_grant_we", 32'(m_we), 32'd0);
    if_req = 0; dreq = 0;
    tick(); tick(); tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(2))
          0: p_ready = 95;
          1: p_ready = 70;
          default: p_ready = 30;
        endcase
      end
      if ($urandom_range(599) == 0) begin
        RSTN = 0;
        tick();
        RSTN = 1;
        f_done = 0; d_done = 0;
      end
      rand_drive();
      tick();
    end
    if_req = 0; dreq = 0;
    repeat (MaxWait + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
